// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, ALU, write-register select and the EX/MEM register.
// The iterative multiply/divide unit with HI/LO is built only when EX_STAGE_MULDIV_EN is defined.
module ex_stage (
    input  logic        clk,
    input  logic        resetn,
    input  logic        regwritee,
    input  logic        memtorege,
    input  logic        memwritee,
    input  logic        alusrce,
    input  logic        jumplinke,
    input  logic [1:0]  regdste,
    input  logic [2:0]  alucontrole,
    input  logic [31:0] rd1e,
    input  logic [31:0] rd2e,
    input  logic [31:0] signimme,
    input  logic [31:0] pcplus4e,
    input  logic [4:0]  rse,
    input  logic [4:0]  rte,
    input  logic [4:0]  rde,
    input  logic        mdstarte,
    input  logic [1:0]  mdope,
    input  logic [1:0]  mfsele,
    input  logic [1:0]  forwardae,
    input  logic [1:0]  forwardbe,
    input  logic [31:0] resultw,
    output logic        regwritem,
    output logic        memtoregm,
    output logic        memwritem,
    output logic [31:0] aluoutm,
    output logic [31:0] writedatam,
    output logic [4:0]  writeregm,
    output logic        mdbusy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int unsigned XLEN = 32;
    localparam int unsigned RLEN = 5;

    logic [XLEN-1:0] srca;
    logic [XLEN-1:0] srcb;
    logic [XLEN-1:0] writedata;
    logic [XLEN-1:0] alu_res;
    logic [XLEN-1:0] ex_res;
    logic [RLEN-1:0] writereg;
    logic            bubble;

    // rs is consumed by the hazard unit, not here
    logic unused_rse;
    assign unused_rse = ^rse;

    // Operand forwarding muxes
    always_comb begin
        srca      = rd1e;
        writedata = rd2e;
        case (forwardae)
            2'b10:   srca = aluoutm;
            2'b01:   srca = resultw;
            default: srca = rd1e;
        endcase
        case (forwardbe)
            2'b10:   writedata = aluoutm;
            2'b01:   writedata = resultw;
            default: writedata = rd2e;
        endcase
        srcb = alusrce ? signimme : writedata;
    end

    always_comb begin
        alu_res = '0;
        case (alucontrole)
            3'b000: alu_res = srca & srcb;
            3'b001: alu_res = srca | srcb;
            3'b010: alu_res = srca + srcb;
            3'b011: alu_res = srca ^ srcb;
            3'b100: alu_res = srca & ~srcb;
            3'b101: alu_res = srca | ~srcb;
            3'b110: alu_res = srca - srcb;
            3'b111: alu_res = XLEN'($signed(srca) < $signed(srcb));
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        writereg = '0;
        case (regdste)
            2'b00:   writereg = rte;
            2'b01:   writereg = rde;
            2'b10:   writereg = RLEN'(31);
            default: writereg = '0;
        endcase
    end

    // Link address wins over HI/LO moves, which win over the ALU
    always_comb begin
        ex_res = alu_res;
        if (jumplinke) begin
            ex_res = pcplus4e;
        end else if (mfsele == 2'b01) begin
            ex_res = hi;
        end else if (mfsele == 2'b10) begin
            ex_res = lo;
        end
    end

    // A HI/LO read while the unit is still computing must not retire
    assign bubble = mdbusy & ((mfsele == 2'b01) | (mfsele == 2'b10));

    always_ff @(posedge clk) begin
        if (!resetn) begin
            regwritem  <= 1'b0;
            memtoregm  <= 1'b0;
            memwritem  <= 1'b0;
            aluoutm    <= '0;
            writedatam <= '0;
            writeregm  <= '0;
        end else begin
            regwritem  <= regwritee & ~bubble;
            memtoregm  <= memtorege & ~bubble;
            memwritem  <= memwritee & ~bubble;
            aluoutm    <= ex_res;
            writedatam <= writedata;
            writeregm  <= writereg;
        end
    end

`ifdef EX_STAGE_MULDIV_EN
    localparam int unsigned CLEN = 6;
    localparam logic [CLEN-1:0] LAST_STEP = CLEN'(XLEN - 1);

    typedef enum logic {MD_IDLE, MD_BUSY} md_state_e;

    md_state_e       state_q, state_d;
    logic [CLEN-1:0] cnt_q, cnt_d;
    logic [1:0]      op_q, op_d;
    logic            neg_q, neg_d;
    logic            rneg_q, rneg_d;
    logic            busy_q, busy_d;
    logic [XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0] qr_q, qr_d;
    logic [XLEN-1:0] mc_q, mc_d;
    logic [XLEN-1:0] hi_q, hi_d;
    logic [XLEN-1:0] lo_q, lo_d;

    logic            a_neg, b_neg;
    logic [XLEN-1:0] a_mag, b_mag;
    logic [XLEN:0]   msum;
    logic [XLEN-1:0] macc, mqr;
    logic [XLEN:0]   dshift;
    logic [XLEN+1:0] ddiff;
    logic            dfit;
    logic [XLEN-1:0] dacc, dqr;
    logic [2*XLEN-1:0] prod;

    // Signed ops (even opcode bit 0) work on magnitudes and fix the sign at the end
    assign a_neg = ~mdope[0] & srca[XLEN-1];
    assign b_neg = ~mdope[0] & srcb[XLEN-1];
    assign a_mag = a_neg ? -srca : srca;
    assign b_mag = b_neg ? -srcb : srcb;

    // Multiply step: conditional add into the upper half, then shift the pair right
    assign msum = {1'b0, acc_q} + (qr_q[0] ? {1'b0, mc_q} : '0);
    assign macc = msum[XLEN:1];
    assign mqr  = {msum[0], qr_q[XLEN-1:1]};
    assign prod = {macc, mqr};

    // Restoring divide step: shift in the next dividend bit, keep the difference if non-negative
    assign dshift = {acc_q, qr_q[XLEN-1]};
    assign ddiff  = {1'b0, dshift} - {2'b00, mc_q};
    assign dfit   = ~ddiff[XLEN+1];
    assign dacc   = dfit ? ddiff[XLEN-1:0] : dshift[XLEN-1:0];
    assign dqr    = {qr_q[XLEN-2:0], dfit};

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= MD_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            busy_q  <= 1'b0;
            acc_q   <= '0;
            qr_q    <= '0;
            mc_q    <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            neg_q   <= neg_d;
            rneg_q  <= rneg_d;
            busy_q  <= busy_d;
            acc_q   <= acc_d;
            qr_q    <= qr_d;
            mc_q    <= mc_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        neg_d   = neg_q;
        rneg_d  = rneg_q;
        busy_d  = busy_q;
        acc_d   = acc_q;
        qr_d    = qr_q;
        mc_d    = mc_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            MD_IDLE: begin
                if (mdstarte) begin
                    state_d = MD_BUSY;
                    busy_d  = 1'b1;
                    cnt_d   = '0;
                    op_d    = mdope;
                    neg_d   = a_neg ^ b_neg;
                    rneg_d  = a_neg;
                    acc_d   = '0;
                    qr_d    = a_mag;
                    mc_d    = b_mag;
                end
            end
            MD_BUSY: begin
                cnt_d = cnt_q + CLEN'(1);
                if (op_q[1]) begin
                    acc_d = dacc;
                    qr_d  = dqr;
                end else begin
                    acc_d = macc;
                    qr_d  = mqr;
                end
                if (cnt_q == LAST_STEP) begin
                    state_d = MD_IDLE;
                    busy_d  = 1'b0;
                    if (op_q[1]) begin
                        lo_d = (mc_q == '0) ? '1 : (neg_q ? -dqr : dqr);
                        hi_d = rneg_q ? -dacc : dacc;
                    end else begin
                        {hi_d, lo_d} = neg_q ? -prod : prod;
                    end
                end
            end
            default: begin
                state_d = MD_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign mdbusy = busy_q;
    assign hi     = hi_q;
    assign lo     = lo_q;
`else
    logic unused_md;
    assign unused_md = ^{mdstarte, mdope};

    assign mdbusy = 1'b0;
    assign hi     = '0;
    assign lo     = '0;
`endif

endmodule

// File: tb/tb_ex_stage.sv
// Directed self-checking bench for ex_stage; multiply/divide vectors run only when
// EX_STAGE_MULDIV_EN is defined, otherwise the constant-zero HI/LO behaviour is checked.
module tb_ex_stage;

    logic        clk = 1'b0;
    logic        resetn;
    logic        regwritee, memtorege, memwritee, alusrce, jumplinke;
    logic [1:0]  regdste;
    logic [2:0]  alucontrole;
    logic [31:0] rd1e, rd2e, signimme, pcplus4e;
    logic [4:0]  rse, rte, rde;
    logic        mdstarte;
    logic [1:0]  mdope, mfsele, forwardae, forwardbe;
    logic [31:0] resultw;
    logic        regwritem, memtoregm, memwritem;
    logic [31:0] aluoutm, writedatam;
    logic [4:0]  writeregm;
    logic        mdbusy;
    logic [31:0] hi, lo;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    ex_stage dut (
        .clk(clk), .resetn(resetn),
        .regwritee(regwritee), .memtorege(memtorege), .memwritee(memwritee),
        .alusrce(alusrce), .jumplinke(jumplinke), .regdste(regdste),
        .alucontrole(alucontrole), .rd1e(rd1e), .rd2e(rd2e), .signimme(signimme),
        .pcplus4e(pcplus4e), .rse(rse), .rte(rte), .rde(rde),
        .mdstarte(mdstarte), .mdope(mdope), .mfsele(mfsele),
        .forwardae(forwardae), .forwardbe(forwardbe), .resultw(resultw),
        .regwritem(regwritem), .memtoregm(memtoregm), .memwritem(memwritem),
        .aluoutm(aluoutm), .writedatam(writedatam), .writeregm(writeregm),
        .mdbusy(mdbusy), .hi(hi), .lo(lo)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        regwritee = 0; memtorege = 0; memwritee = 0; alusrce = 0; jumplinke = 0;
        regdste = 2'b00; alucontrole = 3'b000;
        rd1e = 0; rd2e = 0; signimme = 0; pcplus4e = 0;
        rse = 0; rte = 0; rde = 0;
        mdstarte = 0; mdope = 0; mfsele = 0; forwardae = 0; forwardbe = 0; resultw = 0;
    endtask

    task automatic alu_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input string tag);
        rd1e = a; rd2e = b; alucontrole = op; alusrce = 0;
        tick();
        check(tag, aluoutm, exp);
    endtask

`ifdef EX_STAGE_MULDIV_EN
    task automatic run_md(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] ehi, input logic [31:0] elo, input string tag);
        int n;
        rd1e = a; rd2e = b; mdope = op; mdstarte = 1;
        tick();
        mdstarte = 0;
        check({tag, "_busy"}, 32'(mdbusy), 32'd1);
        n = 1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (!mdbusy) break;
            n++;
        end
        check({tag, "_cycles"}, 32'(n), 32'd32);
        check({tag, "_hi"}, hi, ehi);
        check({tag, "_lo"}, lo, elo);
    endtask
`endif

    initial begin
        int n;
        clear_inputs();
        resetn = 0;
        tick();
        check("rst_aluoutm", aluoutm, 32'h0);
        check("rst_writedatam", writedatam, 32'h0);
        check("rst_ctrl", {29'b0, regwritem, memtoregm, memwritem}, 32'h0);
        check("rst_writeregm", 32'(writeregm), 32'h0);
        check("rst_mdbusy", 32'(mdbusy), 32'h0);
        check("rst_hi", hi, 32'h0);
        check("rst_lo", lo, 32'h0);
        resetn = 1;

        // 7 - 5 into rd 9
        rd1e = 7; rd2e = 5; alucontrole = 3'b110; regdste = 2'b01; rde = 9; regwritee = 1;
        tick();
        check("sub_aluoutm", aluoutm, 32'd2);
        check("sub_writeregm", 32'(writeregm), 32'd9);
        check("sub_regwritem", 32'(regwritem), 32'd1);
        check("sub_writedatam", writedatam, 32'd5);

        // ALU code sweep
        alu_op(3'b000, 32'hF0F01234, 32'h0FF08765, 32'h00F00224, "alu_and");
        alu_op(3'b001, 32'hF0F01234, 32'h0FF08765, 32'hFFF09775, "alu_or");
        alu_op(3'b010, 32'hF0F01234, 32'h0FF08765, 32'h00E09999, "alu_add");
        alu_op(3'b011, 32'hF0F01234, 32'h0FF08765, 32'hFF009551, "alu_xor");
        alu_op(3'b100, 32'hF0F01234, 32'h0FF08765, 32'hF0001010, "alu_andn");
        alu_op(3'b101, 32'hF0F01234, 32'h0FF08765, 32'hF0FF7ABE, "alu_orn");
        alu_op(3'b110, 32'hF0F01234, 32'h0FF08765, 32'hE0FF8ACF, "alu_sub");
        alu_op(3'b111, 32'hF0F01234, 32'h0FF08765, 32'h1, "alu_slt_neg");
        alu_op(3'b111, 32'h5, 32'hFFFFFFFF, 32'h0, "alu_slt_pos");
        alu_op(3'b110, 32'h0, 32'h1, 32'hFFFFFFFF, "alu_sub_wrap");

        // Forwarding from MEM into A with an immediate B
        alu_op(3'b010, 32'h10, 32'h0, 32'h10, "fwd_setup");
        forwardae = 2'b10; rd1e = 32'hDEAD; alusrce = 1; signimme = 32'hFFFFFFFF; alucontrole = 3'b010;
        tick();
        check("fwd_a_mem", aluoutm, 32'h0F);
        forwardae = 2'b01; resultw = 32'h20; forwardbe = 2'b10; rd2e = 32'hBEEF;
        alusrce = 0; alucontrole = 3'b001;
        tick();
        check("fwd_a_wb_or", aluoutm, 32'h2F);
        check("fwd_b_mem_wd", writedatam, 32'h0F);
        forwardae = 2'b00; forwardbe = 2'b01; rd1e = 1; resultw = 32'h100; alucontrole = 3'b010;
        tick();
        check("fwd_b_wb", aluoutm, 32'h101);
        check("fwd_b_wb_wd", writedatam, 32'h100);
        forwardbe = 2'b00;

        // Write-register selection and control passthrough
        rte = 7; rde = 9; regdste = 2'b00; memtorege = 1; memwritee = 1;
        tick();
        check("wreg_rt", 32'(writeregm), 32'd7);
        check("ctrl_pass", {29'b0, regwritem, memtoregm, memwritem}, 32'h7);
        regdste = 2'b11; memtorege = 0; memwritee = 0;
        tick();
        check("wreg_zero", 32'(writeregm), 32'd0);
        jumplinke = 1; pcplus4e = 32'h00400010; regdste = 2'b10; rd1e = 32'h1234;
        tick();
        check("jal_aluoutm", aluoutm, 32'h00400010);
        check("jal_writeregm", 32'(writeregm), 32'd31);
        jumplinke = 0; regdste = 2'b01;

`ifdef EX_STAGE_MULDIV_EN
        // MULT -3*4, with an ignored restart and a HI/LO read while busy
        rd1e = 32'hFFFFFFFD; rd2e = 4; mdope = 2'b00; mdstarte = 1; regwritee = 0;
        tick();
        check("mult_busy", 32'(mdbusy), 32'd1);
        rd1e = 99; rd2e = 99; mdope = 2'b11;
        tick();
        mdstarte = 0; rd1e = 0; rd2e = 0;
        mfsele = 2'b10; regwritee = 1; memwritee = 1; memtorege = 1;
        tick();
        check("bubble_ctrl", {29'b0, regwritem, memtoregm, memwritem}, 32'h0);
        check("mult_hi_hold", hi, 32'h0);
        mfsele = 2'b00; memwritee = 0; memtorege = 0;
        n = 3;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (!mdbusy) break;
            n++;
        end
        check("mult_cycles", 32'(n), 32'd32);
        check("mult_hi", hi, 32'hFFFFFFFF);
        check("mult_lo", lo, 32'hFFFFFFF4);
        mfsele = 2'b10;
        tick();
        check("mflo", aluoutm, 32'hFFFFFFF4);
        check("mflo_regwrite", 32'(regwritem), 32'd1);
        mfsele = 2'b01;
        tick();
        check("mfhi", aluoutm, 32'hFFFFFFFF);
        mfsele = 2'b00;

        run_md(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, "multu");
        run_md(2'b10, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFD, "div");
        run_md(2'b11, 32'h12345678, 32'h0, 32'h12345678, 32'hFFFFFFFF, "divu_zero");
        run_md(2'b11, 32'd100, 32'd7, 32'd2, 32'd14, "divu");

        // Abort mid-operation
        rd1e = 32'h00010000; rd2e = 32'h00010000; mdope = 2'b01; mdstarte = 1;
        tick();
        mdstarte = 0;
`else
        mdstarte = 1; mdope = 2'b00; rd1e = 32'hFFFFFFFD; rd2e = 4;
        tick();
        check("nomd_busy", 32'(mdbusy), 32'd0);
        mdstarte = 0; mfsele = 2'b01; regwritee = 1;
        tick();
        check("nomd_mfhi", aluoutm, 32'h0);
        check("nomd_no_bubble", 32'(regwritem), 32'd1);
        mfsele = 2'b10;
        tick();
        check("nomd_mflo", aluoutm, 32'h0);
        check("nomd_hi", hi, 32'h0);
        check("nomd_lo", lo, 32'h0);
        mfsele = 2'b00;
`endif
        rd1e = 5; rd2e = 3; alucontrole = 3'b010; regwritee = 1; memtorege = 1; memwritee = 1;
        rde = 9; regdste = 2'b01;
        for (int i = 0; i < 9; i++) tick();
        check("pre_rst_busy", 32'(mdbusy),
`ifdef EX_STAGE_MULDIV_EN
              32'd1);
`else
              32'd0);
`endif
        resetn = 0;
        tick();
        check("abort_mdbusy", 32'(mdbusy), 32'h0);
        check("abort_hi", hi, 32'h0);
        check("abort_lo", lo, 32'h0);
        check("abort_aluoutm", aluoutm, 32'h0);
        check("abort_writedatam", writedatam, 32'h0);
        check("abort_writeregm", 32'(writeregm), 32'h0);
        check("abort_ctrl", {29'b0, regwritem, memtoregm, memwritem}, 32'h0);
        resetn = 1;
        tick();
        check("post_rst_busy", 32'(mdbusy), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
